// File: rtl/led_pattern_gen_pkg.sv
// Shared types and DIP bit positions for the LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_THERMO = 2'b11
  } led_mode_e;

  // BOUNCE uses left/right; THERMO reuses LEFT as fill and RIGHT as drain.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } led_dir_e;

  localparam int RUN_BIT  = 0;
  localparam int MODE_LSB = 1;
  localparam int DIP_W    = 3;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Board-facing signal bundle: DIP switches in, LED pattern and step pulse out.
interface led_pattern_gen_if #(
  parameter int N_LEDS = 8
);
  logic [2:0]        i_dip;
  logic [N_LEDS-1:0] o_led;
  logic              o_step;

  modport master (output i_dip, input o_led, input o_step);
  modport slave  (input i_dip, output o_led, output o_step);
endinterface

// File: rtl/led_pattern_gen_dip_debounce.sv
// Vector-wide 2-flop synchroniser plus stability filter for the DIP switches.
// The filter is built only when LED_PATTERN_DEBOUNCE_EN is defined; otherwise acc is the synchroniser output.
module dip_debounce #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dip,
  output logic [WIDTH-1:0] acc
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("dip_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dip;
      sync2_q <= sync1_q;
    end
  end

`ifdef LED_PATTERN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts consecutive cycles that sync2_q has held cand_q while differing from acc_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (sync2_q == acc_q) begin
      cnt_q <= '0;
    end else if (sync2_q != cand_q) begin
      cand_q <= sync2_q;
      cnt_q  <= CNT_W'(1);
    end else if (cnt_q == CNT_LAST) begin
      acc_q <= cand_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign acc = acc_q;
`else
  assign acc = sync2_q;
`endif

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: filtered DIP run/mode, prescaled stepping of an N-bit pattern.
// Optional DIP debounce filter enabled by LED_PATTERN_DEBOUNCE_EN.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS          = 8,
  parameter int PRESCALE        = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  led_pattern_gen_if.slave bus
);

  if (N_LEDS < 2 || PRESCALE < 1) begin : g_bad_cfg
    $error("led_pattern_gen: N_LEDS must be >= 2 and PRESCALE >= 1");
  end

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [N_LEDS-1:0] ONE_HOT0 = N_LEDS'(1);

  logic [DIP_W-1:0]  dip_acc;
  logic              run_acc;
  led_mode_e         mode_acc;
  led_mode_e         mode_q;
  led_dir_e          dir_q, dir_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic [PS_W-1:0]   cnt_q, cnt_d;
  logic              step_q, step_d;
  logic              mode_chg;

  dip_debounce #(
    .WIDTH          (DIP_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dip (
    .clk(clk),
    .rst(rst),
    .dip(bus.i_dip),
    .acc(dip_acc)
  );

  assign run_acc  = dip_acc[RUN_BIT];
  assign mode_acc = led_mode_e'(dip_acc[MODE_LSB +: 2]);
  // mode_q trails the accepted mode by one cycle, so a change is seen for exactly one cycle.
  assign mode_chg = (mode_acc != mode_q);

  function automatic logic [N_LEDS-1:0] reload_val(led_mode_e m);
    case (m)
      MODE_ROTATE, MODE_BOUNCE: return ONE_HOT0;
      default:                  return '0;
    endcase
  endfunction

  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (mode_chg) begin
      // Reload takes priority over any coincident terminal count.
      led_d = reload_val(mode_acc);
      dir_d = DIR_LEFT;
      cnt_d = '0;
    end else if (run_acc) begin
      if (cnt_q == PS_LAST) begin
        cnt_d  = '0;
        step_d = 1'b1;
        case (mode_q)
          MODE_COUNT:  led_d = led_q + N_LEDS'(1);
          MODE_ROTATE: led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
          MODE_BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              if (led_q[N_LEDS-1]) begin
                led_d = led_q >> 1;
                dir_d = DIR_RIGHT;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d = led_q << 1;
                dir_d = DIR_LEFT;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          MODE_THERMO: begin
            if (dir_q == DIR_LEFT) begin
              led_d = {led_q[N_LEDS-2:0], 1'b1};
              if (&led_q[N_LEDS-2:0]) dir_d = DIR_RIGHT;
            end else begin
              led_d = led_q >> 1;
              if (led_q[N_LEDS-1:1] == '0) dir_d = DIR_LEFT;
            end
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q  <= '0;
      dir_q  <= DIR_LEFT;
      cnt_q  <= '0;
      step_q <= 1'b0;
      mode_q <= MODE_COUNT;
    end else begin
      led_q  <= led_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      mode_q <= mode_acc;
    end
  end

  assign bus.o_led  = led_q;
  assign bus.o_step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: table-driven pattern sequences, directed corner cases, random DIP activity vs. a reference model.
module tb_led_pattern_gen;

  localparam int N_LEDS          = 4;
  localparam int PRESCALE        = 4;
  localparam int DEBOUNCE_CYCLES = 8;
`ifdef LED_PATTERN_DEBOUNCE_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = 2 + DEBOUNCE_CYCLES + 1;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_pattern_gen_if #(.N_LEDS(N_LEDS)) bus ();

  led_pattern_gen #(
    .N_LEDS         (N_LEDS),
    .PRESCALE       (PRESCALE),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: pin history, accepted DIP value, and pattern as (mode, step index).
  logic [2:0] hist[$];
  logic [2:0] m_acc;
  logic [1:0] m_mode;
  int         m_idx;
  int         m_pcnt;
  logic       m_step;

  typedef struct {
    logic [2:0]  dip;
    logic [3:0]  reload;
    int          nsteps;
    logic [63:0] seq;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_LEDS-1:0] pat(input logic [1:0] m, input int idx);
    int p, c;
    case (m)
      2'b00: return N_LEDS'(idx % (1 << N_LEDS));
      2'b01: return N_LEDS'(1 << (idx % N_LEDS));
      2'b10: begin
        p = idx % (2 * (N_LEDS - 1));
        c = (p < N_LEDS) ? p : 2 * (N_LEDS - 1) - p;
        return N_LEDS'(1 << c);
      end
      default: begin
        p = idx % (2 * N_LEDS);
        c = (p <= N_LEDS) ? p : 2 * N_LEDS - p;
        return N_LEDS'((1 << c) - 1);
      end
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (DEBOUNCE_CYCLES + 3) hist.push_back(3'b000);
    m_acc  = 3'b000;
    m_mode = 2'b00;
    m_idx  = 0;
    m_pcnt = 0;
    m_step = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0] v;
    bit         ok;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_acc[2:1] != m_mode) begin
      m_mode = m_acc[2:1];
      m_idx  = 0;
      m_pcnt = 0;
      m_step = 1'b0;
    end else if (m_acc[0]) begin
      if (m_pcnt == PRESCALE - 1) begin
        m_pcnt = 0;
        m_idx++;
        m_step = 1'b1;
      end else begin
        m_pcnt++;
        m_step = 1'b0;
      end
    end else begin
      m_step = 1'b0;
    end
    hist.push_back(bus.i_dip);
    if (hist.size() > DEBOUNCE_CYCLES + 3) void'(hist.pop_front());
    if (FILT) begin
      v  = hist[0];
      ok = 1'b1;
      for (int i = 1; i < DEBOUNCE_CYCLES; i++) if (hist[i] != v) ok = 1'b0;
      if (ok && v != m_acc) m_acc = v;
    end else begin
      m_acc = hist[hist.size() - 2];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_led", 32'(bus.o_led), 32'(pat(m_mode, m_idx)));
    chk("model_step", 32'(bus.o_step), 32'(m_step));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_dip = 3'b000;
    model_reset();
    repeat (3) begin
      cyc();
      chk("reset_led", 32'(bus.o_led), 32'h0);
    end
    rst = 1'b0;
  endtask

  task automatic wait_step(input int bound, output int found, output int gap);
    found = 0;
    gap   = 0;
    while (found == 0 && gap < bound) begin
      cyc();
      gap++;
      if (bus.o_step) found = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int found, gap, x;
    logic [3:0] held;

    tbl[0] = '{dip: 3'b001, reload: 4'h0, nsteps: 16, seq: 64'h0FED_CBA9_8765_4321};
    tbl[1] = '{dip: 3'b101, reload: 4'h1, nsteps: 7,  seq: 64'h0000_0000_0212_4842};
    tbl[2] = '{dip: 3'b111, reload: 4'h0, nsteps: 9,  seq: 64'h0000_0001_0137_F731};
    tbl[3] = '{dip: 3'b011, reload: 4'h1, nsteps: 4,  seq: 64'h0000_0000_0000_1842};

    bus.i_dip = 3'b000;
    model_reset();

    for (int t = 0; t < 4; t++) begin
      do_reset();
      bus.i_dip = tbl[t].dip;
      repeat (LAT + 1) cyc();
      chk("reload", 32'(bus.o_led), 32'(tbl[t].reload));
      for (int s = 0; s < tbl[t].nsteps; s++) begin
        wait_step(PRESCALE + 2, found, gap);
        chk("step_seen", 32'(found), 32'd1);
        chk("step_val", 32'(bus.o_led), 32'(tbl[t].seq[4*s +: 4]));
        if (s > 0) chk("step_gap", 32'(gap), 32'(PRESCALE));
      end

      if (t == 2) begin
        // Pause mid-THERMO, then resume.
        repeat (2) cyc();
        bus.i_dip = 3'b110;
        repeat (LAT + 1) cyc();
        held = bus.o_led;
        repeat (12) cyc();
        chk("pause_hold", 32'(bus.o_led), 32'(held));
        bus.i_dip = 3'b111;
        wait_step(LAT + PRESCALE + 2, found, gap);
        chk("resume_step", 32'(found), 32'd1);
      end
    end

    // Glitches on the mode bits while in ROTATE.
    for (int g = 1; g < DEBOUNCE_CYCLES; g += 2) begin
      bus.i_dip = 3'b101;
      repeat (g) cyc();
      bus.i_dip = 3'b011;
      repeat (4) cyc();
    end
    repeat (LAT + 2) cyc();

    // Stable change to THERMO: accepted after LAT edges, reload one edge later.
    bus.i_dip = 3'b111;
    repeat (LAT) cyc();
    chk("pre_reload_nonzero", 32'(bus.o_led != 4'h0), 32'd1);
    cyc();
    chk("reload_latency", 32'(bus.o_led), 32'h0);
    chk("reload_no_step", 32'(bus.o_step), 32'h0);

    // Accepted mode change lands on the prescaler terminal count.
    wait_step(2 * PRESCALE + 2, found, gap);
    chk("collision_sync", 32'(found), 32'd1);
    x = (((PRESCALE - 1 - LAT) % PRESCALE) + PRESCALE) % PRESCALE;
    repeat (x) cyc();
    bus.i_dip = 3'b011;
    repeat (LAT) cyc();
    cyc();
    chk("collision_led", 32'(bus.o_led), 32'h1);
    chk("collision_step", 32'(bus.o_step), 32'h0);

    // Asynchronous reset between edges.
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("async_led", 32'(bus.o_led), 32'h0);
    chk("async_step", 32'(bus.o_step), 32'h0);
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;

    // Random DIP activity against the model.
    repeat (150) begin
      bus.i_dip = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 24)) cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
